// File: rtl/booth_r4_mac_seq.sv
// Sequential radix-4 Booth multiplier with optional saturating accumulate.
// Retires two multiplier bits per cycle; valid/ready on both sides.
`timescale 1ns/1ps
module booth_r4_mac_seq #(
    parameter int WA   = 16,
    parameter int WB   = 16,
    parameter int WACC = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WA-1:0]      a,
    input  logic [WB-1:0]      b,
    input  logic               signed_mode,
    input  logic               acc_en,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WA+WB-1:0]   product,
    output logic [WACC-1:0]    acc,
    output logic               acc_ovf,
    output logic               busy
);

    localparam int WP    = WA + WB;
    localparam int NSTEP = WB / 2 + 1;
    localparam int WS    = WP + 2;
    localparam int WBX   = WB + 3;
    localparam int WCNT  = $clog2(NSTEP + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WS-1:0]     r_a_sh;
    logic [WS-1:0]     r_sum;
    logic [WBX-1:0]    r_b_sh;
    logic [WCNT-1:0]   r_step;
    logic              r_signed;
    logic              r_acc_en;
    logic              r_acc_clr;
    logic [WP-1:0]     r_product;
    logic [WACC-1:0]   r_acc;
    logic              r_acc_ovf;

    logic              w_accept;
    logic              w_last;
    logic [WS-1:0]     w_pp;
    logic [WS-1:0]     w_sum;
    logic [WP-1:0]     w_prod;
    logic [WACC-1:0]   w_p_ext;
    logic [WACC:0]     w_acc_sum;
    logic [WACC-1:0]   w_acc_nxt;
    logic              w_ovf_nxt;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_step == WCNT'(NSTEP - 1));

    assign product  = r_product;
    assign acc      = r_acc;
    assign acc_ovf  = r_acc_ovf;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned
        // (otherwise synthesis infers a latch).
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_CALC;
            S_CALC:  if (w_last)   w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = w_accept ? S_CALC : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    // Booth digit from the low triplet; r_a_sh already carries weight 4^i.
    always_comb begin
        case (r_b_sh[2:0])
            3'b001, 3'b010: w_pp = r_a_sh;
            3'b011:         w_pp = r_a_sh << 1;
            3'b100:         w_pp = -(r_a_sh << 1);
            3'b101, 3'b110: w_pp = -r_a_sh;
            default:        w_pp = '0;
        endcase
    end

    assign w_sum     = r_sum + w_pp;
    assign w_prod    = w_sum[WP-1:0];
    assign w_p_ext   = r_signed ? {{(WACC-WP){w_prod[WP-1]}}, w_prod}
                                : {{(WACC-WP){1'b0}}, w_prod};
    assign w_acc_sum = {r_acc[WACC-1], r_acc} + {w_p_ext[WACC-1], w_p_ext};

    // Top two bits of the one-bit-wider sum disagree exactly on overflow.
    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_acc_ovf;
        if (r_acc_en) begin
            if (r_acc_clr) begin
                w_acc_nxt = w_p_ext;
                w_ovf_nxt = 1'b0;
            end else if (w_acc_sum[WACC:WACC-1] == 2'b01) begin
                w_acc_nxt = {1'b0, {(WACC-1){1'b1}}};
                w_ovf_nxt = 1'b1;
            end else if (w_acc_sum[WACC:WACC-1] == 2'b10) begin
                w_acc_nxt = {1'b1, {(WACC-1){1'b0}}};
                w_ovf_nxt = 1'b1;
            end else begin
                w_acc_nxt = w_acc_sum[WACC-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_sum     <= '0;
            r_step    <= '0;
            r_signed  <= 1'b0;
            r_acc_en  <= 1'b0;
            r_acc_clr <= 1'b0;
            r_product <= '0;
            r_acc     <= '0;
            r_acc_ovf <= 1'b0;
        end else if (w_accept) begin
            r_a_sh    <= signed_mode ? {{(WS-WA){a[WA-1]}}, a} : {{(WS-WA){1'b0}}, a};
            r_b_sh    <= {(signed_mode ? {2{b[WB-1]}} : 2'b00), b, 1'b0};
            r_sum     <= '0;
            r_step    <= '0;
            r_signed  <= signed_mode;
            r_acc_en  <= acc_en;
            r_acc_clr <= acc_clr;
        end else if (r_state == S_CALC) begin
            r_sum  <= w_sum;
            r_a_sh <= r_a_sh << 2;
            r_b_sh <= r_b_sh >> 2;
            r_step <= r_step + WCNT'(1);
            if (w_last) begin
                r_product <= w_prod;
                r_acc     <= w_acc_nxt;
                r_acc_ovf <= w_ovf_nxt;
            end
        end
    end

endmodule
